// File: rtl/processorci_bus_pkg.sv
// Shared definitions for the single-memory Wishbone bus adapters:
// the adapter FSM states and the port-select encoding.
package processorci_bus_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } bus_state_e;

    localparam logic PORT_INSTR = 1'b0;
    localparam logic PORT_DATA  = 1'b1;

endpackage

// File: rtl/bus_watchdog.sv
// Cycle counter for a Wishbone cycle waiting on ack; expired_o is high in the
// LIMIT_CYCLES-th enabled cycle since the last clear. LIMIT_CYCLES = 0 disables it.
module bus_watchdog #(
    parameter int unsigned LIMIT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CW = (LIMIT_CYCLES == 0) ? 1 : $clog2(LIMIT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = (LIMIT_CYCLES == 0) ? '0 : CW'(LIMIT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Saturates at LAST so a stuck cycle can never wrap back below the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q < LAST)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (LIMIT_CYCLES != 0) && enable_i && (cnt_q >= LAST);

endmodule

// File: rtl/obi_wb_arbiter.sv
// Round-robin bridge from the cve2 instruction and data OBI ports onto one
// Wishbone classic master, one outstanding transaction, with an ack watchdog.
module obi_wb_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    instr_req_i,
    input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
    output logic                    instr_gnt_o,
    output logic                    instr_rvalid_o,
    output logic [DATA_WIDTH-1:0]   instr_rdata_o,
    output logic                    instr_err_o,

    input  logic                    data_req_i,
    input  logic                    data_we_i,
    input  logic [DATA_WIDTH/8-1:0] data_be_i,
    input  logic [ADDR_WIDTH-1:0]   data_addr_i,
    input  logic [DATA_WIDTH-1:0]   data_wdata_i,
    output logic                    data_gnt_o,
    output logic                    data_rvalid_o,
    output logic                    data_err_o,
    output logic [DATA_WIDTH-1:0]   data_rdata_o,

    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    output logic [DATA_WIDTH/8-1:0] wb_sel_o,
    output logic [ADDR_WIDTH-1:0]   wb_addr_o,
    output logic [DATA_WIDTH-1:0]   wb_data_o,
    input  logic [DATA_WIDTH-1:0]   wb_data_i,
    input  logic                    wb_ack_i
);

    import processorci_bus_pkg::*;

    localparam int unsigned SEL_W = DATA_WIDTH / 8;

    bus_state_e state_q, state_d;
    logic last_grant_q, last_grant_d;
    logic owner_q, owner_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic we_q, we_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic instr_rvalid_q, instr_rvalid_d, instr_err_q, instr_err_d;
    logic data_rvalid_q, data_rvalid_d, data_err_q, data_err_d;
    logic [DATA_WIDTH-1:0] instr_rdata_q, instr_rdata_d, data_rdata_q, data_rdata_d;

    logic instr_gnt, data_gnt, pick;
    logic resp_valid, resp_err;
    logic [DATA_WIDTH-1:0] resp_data;
    logic wd_expired;

    bus_watchdog #(
        .LIMIT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .clear_i   (state_q == IDLE),
        .enable_i  (state_q == BUS),
        .expired_o (wd_expired)
    );

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        owner_d       = owner_q;
        addr_d        = addr_q;
        we_d          = we_q;
        sel_d         = sel_q;
        wdata_d       = wdata_q;
        instr_gnt     = 1'b0;
        data_gnt      = 1'b0;
        pick          = PORT_INSTR;
        resp_valid    = 1'b0;
        resp_err      = 1'b0;
        resp_data     = '0;
        instr_rvalid_d = 1'b0;
        instr_err_d    = 1'b0;
        instr_rdata_d  = instr_rdata_q;
        data_rvalid_d  = 1'b0;
        data_err_d     = 1'b0;
        data_rdata_d   = data_rdata_q;

        case (state_q)
            IDLE: begin
                if (instr_req_i || data_req_i) begin
                    // On a tie, the port that did not win last time goes first.
                    pick = (data_req_i && (!instr_req_i || (last_grant_q == PORT_INSTR)))
                           ? PORT_DATA : PORT_INSTR;
                    owner_d      = pick;
                    last_grant_d = pick;
                    state_d      = BUS;
                    if (pick == PORT_DATA) begin
                        data_gnt = 1'b1;
                        addr_d   = data_addr_i;
                        we_d     = data_we_i;
                        sel_d    = data_be_i;
                        wdata_d  = data_wdata_i;
                    end else begin
                        instr_gnt = 1'b1;
                        addr_d    = instr_addr_i;
                        we_d      = 1'b0;
                        sel_d     = '1;
                        wdata_d   = '0;
                    end
                end
            end
            BUS: begin
                if (wb_ack_i) begin
                    resp_valid = 1'b1;
                    resp_data  = we_q ? '0 : wb_data_i;
                    state_d    = IDLE;
                end else if (wd_expired) begin
                    resp_valid = 1'b1;
                    resp_err   = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (resp_valid) begin
            if (owner_q == PORT_DATA) begin
                data_rvalid_d = 1'b1;
                data_err_d    = resp_err;
                data_rdata_d  = resp_data;
            end else begin
                instr_rvalid_d = 1'b1;
                instr_err_d    = resp_err;
                instr_rdata_d  = resp_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            last_grant_q   <= PORT_INSTR;
            owner_q        <= PORT_INSTR;
            addr_q         <= '0;
            we_q           <= 1'b0;
            sel_q          <= '0;
            wdata_q        <= '0;
            instr_rvalid_q <= 1'b0;
            instr_err_q    <= 1'b0;
            instr_rdata_q  <= '0;
            data_rvalid_q  <= 1'b0;
            data_err_q     <= 1'b0;
            data_rdata_q   <= '0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            owner_q        <= owner_d;
            addr_q         <= addr_d;
            we_q           <= we_d;
            sel_q          <= sel_d;
            wdata_q        <= wdata_d;
            instr_rvalid_q <= instr_rvalid_d;
            instr_err_q    <= instr_err_d;
            instr_rdata_q  <= instr_rdata_d;
            data_rvalid_q  <= data_rvalid_d;
            data_err_q     <= data_err_d;
            data_rdata_q   <= data_rdata_d;
        end
    end

    // Grants are combinational from req, so they are masked while reset is held.
    assign instr_gnt_o    = instr_gnt & rst_n;
    assign data_gnt_o     = data_gnt & rst_n;

    assign instr_rvalid_o = instr_rvalid_q;
    assign instr_err_o    = instr_err_q;
    assign instr_rdata_o  = instr_rdata_q;
    assign data_rvalid_o  = data_rvalid_q;
    assign data_err_o     = data_err_q;
    assign data_rdata_o   = data_rdata_q;

    assign wb_cyc_o  = (state_q == BUS);
    assign wb_stb_o  = (state_q == BUS);
    assign wb_we_o   = we_q;
    assign wb_sel_o  = sel_q;
    assign wb_addr_o = addr_q;
    assign wb_data_o = wdata_q;

endmodule

// File: tb/tb_obi_wb_arbiter.sv
// Scoreboard bench for obi_wb_arbiter: stimulus predicts grants, bus cycles and
// responses into queues; a negedge monitor and a Wishbone slave model consume them.
module tb_obi_wb_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TO = 8;
    localparam bit P_I = 1'b0;
    localparam bit P_D = 1'b1;

    logic clk = 1'b0;
    logic rst_n;
    logic instr_req_i, instr_gnt_o, instr_rvalid_o, instr_err_o;
    logic [AW-1:0] instr_addr_i;
    logic [DW-1:0] instr_rdata_o;
    logic data_req_i, data_we_i, data_gnt_o, data_rvalid_o, data_err_o;
    logic [SW-1:0] data_be_i;
    logic [AW-1:0] data_addr_i;
    logic [DW-1:0] data_wdata_i, data_rdata_o;
    logic wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;
    logic [SW-1:0] wb_sel_o;
    logic [AW-1:0] wb_addr_o;
    logic [DW-1:0] wb_data_o, wb_data_i;

    always #5 clk = ~clk;

    obi_wb_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
        .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
        .data_rvalid_o(data_rvalid_o), .data_err_o(data_err_o), .data_rdata_o(data_rdata_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
        .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .wb_data_i(wb_data_i), .wb_ack_i(wb_ack_i)
    );

    typedef struct { bit v; logic [AW-1:0] addr; logic we; logic [SW-1:0] be; logic [DW-1:0] wdata; } req_t;
    typedef struct { bit port; int at; } gnt_t;
    typedef struct { logic [AW-1:0] addr; logic we; logic [SW-1:0] sel; logic [DW-1:0] wdata; int start_at; int end_at; } wb_t;
    typedef struct { int w; logic [DW-1:0] data; } slv_t;
    typedef struct { bit port; logic [DW-1:0] rdata; bit err; int at; } rsp_t;

    gnt_t exp_gnt[$];
    wb_t  exp_wb[$];
    slv_t slv_q[$];
    rsp_t exp_rsp[$];

    req_t ip, dp;
    bit   last_port;
    logic stray_ack = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", nm, act, exp, cyc);
        end
    endtask

    task automatic bad(input string nm);
        checks++;
        failures++;
        $display("FAIL %s unexpected event at cycle=%0d", nm, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_reqs();
        instr_req_i  = ip.v;
        instr_addr_i = ip.addr;
        data_req_i   = dp.v;
        data_addr_i  = dp.addr;
        data_we_i    = dp.we;
        data_be_i    = dp.be;
        data_wdata_i = dp.wdata;
    endtask

    task automatic fill_instr();
        if (!ip.v) ip = '{v:1'b1, addr:($urandom & 32'h0000_FFFC), we:1'b0, be:4'hF, wdata:32'h0};
    endtask

    task automatic fill_data();
        if (!dp.v) dp = '{v:1'b1, addr:$urandom, we:1'($urandom_range(0, 1)),
                          be:4'($urandom_range(1, 15)), wdata:$urandom};
    endtask

    // Reference model: round-robin with one outstanding transaction; the slave
    // acks on stb cycle w (0-based) unless the watchdog limit TO comes first.
    task automatic issue(input int w, input logic [DW-1:0] rd, output int dur);
        bit win;
        req_t r;
        wb_t e;
        int s, eff;
        s = cyc;
        if (ip.v && dp.v) win = (last_port == P_I) ? P_D : P_I;
        else              win = dp.v ? P_D : P_I;
        r   = win ? dp : ip;
        eff = (w < TO) ? w : TO - 1;
        dur = 2 + eff;
        exp_gnt.push_back('{port:win, at:s});
        e.addr = r.addr;
        e.we = win ? r.we : 1'b0;
        e.sel = win ? r.be : 4'hF;
        e.wdata = r.wdata;
        e.start_at = s + 1;
        e.end_at = s + dur;
        exp_wb.push_back(e);
        slv_q.push_back('{w:w, data:rd});
        exp_rsp.push_back('{port:win, rdata:((w >= TO) || e.we) ? 32'h0 : rd, err:(w >= TO), at:s + dur});
        last_port = win;
        if (win) dp.v = 1'b0; else ip.v = 1'b0;
        step();
        drive_reqs();
    endtask

    task automatic run_slot(input int w, input logic [DW-1:0] rd);
        int dur;
        drive_reqs();
        if (!ip.v && !dp.v) begin
            step();
        end else begin
            issue(w, rd, dur);
            repeat (dur - 1) step();
        end
    endtask

    // Wishbone slave: acks on stb cycle w of each bus cycle, else drives noise.
    initial begin : slave
        slv_t cs;
        int cnt;
        bit active;
        cs = '{w:99, data:32'h0};
        cnt = 0;
        active = 1'b0;
        wb_ack_i = 1'b0;
        wb_data_i = '0;
        forever begin
            @(posedge clk);
            #3;
            if (wb_stb_o) begin
                if (!active) begin
                    active = 1'b1;
                    cnt = 0;
                    if (slv_q.size() > 0) cs = slv_q.pop_front();
                    else cs = '{w:99, data:32'h0};
                end else begin
                    cnt++;
                end
            end else begin
                active = 1'b0;
            end
            wb_ack_i  = stray_ack || (active && (cnt == cs.w));
            wb_data_i = (active && (cnt == cs.w)) ? cs.data : $urandom;
        end
    end

    initial begin : monitor
        wb_t cur;
        gnt_t g;
        rsp_t r;
        bit prev_stb;
        prev_stb = 1'b0;
        cur = '{addr:'0, we:1'b0, sel:'0, wdata:'0, start_at:0, end_at:0};
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stb = 1'b0;
            end else begin
                if (instr_gnt_o && data_gnt_o) begin
                    bad("dual_gnt");
                end else if (instr_gnt_o || data_gnt_o) begin
                    if (exp_gnt.size() == 0) bad("unexpected_gnt");
                    else begin
                        g = exp_gnt.pop_front();
                        chk("gnt_port", 64'(data_gnt_o), 64'(g.port));
                        chk("gnt_cycle", 64'(cyc), 64'(g.at));
                    end
                end

                if (wb_stb_o && !prev_stb) begin
                    if (exp_wb.size() == 0) bad("unexpected_stb");
                    else begin
                        cur = exp_wb.pop_front();
                        chk("wb_start_cycle", 64'(cyc), 64'(cur.start_at));
                        chk("wb_fields", {wb_cyc_o, wb_addr_o, wb_we_o, wb_sel_o},
                            {1'b1, cur.addr, cur.we, cur.sel});
                        if (cur.we) chk("wb_wdata", 64'(wb_data_o), 64'(cur.wdata));
                    end
                end else if (wb_stb_o) begin
                    chk("wb_hold", {wb_cyc_o, wb_addr_o, wb_we_o, wb_sel_o, (cur.we ? wb_data_o : 32'h0)},
                        {1'b1, cur.addr, cur.we, cur.sel, (cur.we ? cur.wdata : 32'h0)});
                end else if (prev_stb) begin
                    chk("wb_end_cycle", 64'(cyc), 64'(cur.end_at));
                    chk("cyc_low", 64'(wb_cyc_o), 64'h0);
                end
                prev_stb = wb_stb_o;

                if (instr_rvalid_o && data_rvalid_o) begin
                    bad("dual_rvalid");
                end else if (instr_rvalid_o || data_rvalid_o) begin
                    if (exp_rsp.size() == 0) bad("unexpected_rvalid");
                    else begin
                        r = exp_rsp.pop_front();
                        chk("rsp_port", 64'(data_rvalid_o), 64'(r.port));
                        chk("rsp_cycle", 64'(cyc), 64'(r.at));
                        chk("rsp_rdata", 64'(data_rvalid_o ? data_rdata_o : instr_rdata_o), 64'(r.rdata));
                        chk("rsp_err", 64'(data_rvalid_o ? data_err_o : instr_err_o), 64'(r.err));
                    end
                end
            end
        end
    end

    initial begin : guard
        #500000;
        $display("FAIL sim_timeout actual=%0d required=finish", cyc);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : stim
        int dur;
        int w;
        rst_n = 1'b0;
        ip = '{v:1'b0, addr:'0, we:1'b0, be:'0, wdata:'0};
        dp = ip;
        last_port = P_I;
        drive_reqs();
        instr_req_i = 1'b1;
        data_req_i = 1'b1;
        #3;
        chk("rst_gnt", {instr_gnt_o, data_gnt_o}, 0);
        chk("rst_wb", {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_addr_o, wb_data_o}, 0);
        chk("rst_rsp", {instr_rvalid_o, instr_err_o, data_rvalid_o, data_err_o}, 0);
        chk("rst_rdata", {instr_rdata_o, data_rdata_o}, 0);
        drive_reqs();
        repeat (2) step();
        rst_n = 1'b1;
        step();

        // Instruction read, zero-wait slave.
        ip = '{v:1'b1, addr:32'h100, we:1'b0, be:4'hF, wdata:32'h0};
        run_slot(0, 32'hDEADBEEF);

        // Both ports requesting continuously for four transactions.
        for (int i = 0; i < 4; i++) begin
            fill_instr();
            fill_data();
            run_slot(0, $urandom);
        end
        while (ip.v || dp.v) run_slot(1, $urandom);

        // Data write with three wait states.
        dp = '{v:1'b1, addr:32'h2000, we:1'b1, be:4'h3, wdata:32'h1234ABCD};
        run_slot(3, 32'h5555AAAA);

        // No ack at all, then a late ack while idle.
        ip = '{v:1'b1, addr:32'h300, we:1'b0, be:4'hF, wdata:32'h0};
        run_slot(99, 32'h0);
        repeat (2) step();
        stray_ack = 1'b1;
        step();
        stray_ack = 1'b0;
        chk("late_ack_no_rvalid", {instr_rvalid_o, data_rvalid_o}, 0);
        step();
        chk("late_ack_idle", {wb_cyc_o, instr_rvalid_o, data_rvalid_o}, 0);

        // Ack on the same cycle the watchdog expires.
        dp = '{v:1'b1, addr:32'h400, we:1'b0, be:4'hF, wdata:32'h0};
        run_slot(TO - 1, 32'hCAFEF00D);

        // Reset in the middle of a two-wait-state bus cycle.
        dp = '{v:1'b1, addr:32'h500, we:1'b0, be:4'hC, wdata:32'h0};
        drive_reqs();
        issue(2, 32'h0BADF00D, dur);
        step();
        chk("pre_rst_stb", 64'(wb_stb_o), 64'h1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_bus", {wb_cyc_o, wb_stb_o}, 0);
        void'(exp_rsp.pop_back());
        ip.v = 1'b0;
        dp.v = 1'b0;
        last_port = P_I;
        drive_reqs();
        repeat (2) step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("no_rvalid_after_rst", {instr_rvalid_o, data_rvalid_o}, 0);
        end
        fill_instr();
        fill_data();
        run_slot(0, $urandom);
        while (ip.v || dp.v) run_slot(0, $urandom);

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) < 6) fill_instr();
            if ($urandom_range(0, 9) < 6) fill_data();
            w = int'($urandom_range(0, 11));
            if (w == 10) w = TO - 1;
            else if (w == 11) w = 99;
            else w = w % 4;
            run_slot(w, $urandom);
        end
        ip.v = 1'b0;
        dp.v = 1'b0;
        drive_reqs();
        repeat (5) step();

        chk("gnt_queue_empty", 64'(exp_gnt.size()), 64'h0);
        chk("wb_queue_empty", 64'(exp_wb.size()), 64'h0);
        chk("rsp_queue_empty", 64'(exp_rsp.size()), 64'h0);
        chk("slave_queue_empty", 64'(slv_q.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
